// File: rtl/alu_4bits_pkg.sv
// Shared op-codes and scheduler state encoding for the 4-bit ALU scheduler.
package alu_4bits_pkg;
  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_SUB = 2'b01;
  localparam logic [1:0] ALU_OP_AND = 2'b10;
  localparam logic [1:0] ALU_OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_t;
endpackage

// File: rtl/alu_4bits_sched_if.sv
// Request/response bus between N_REQ requesters and the shared ALU scheduler.
interface alu_4bits_sched_if #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [4*N_REQ-1:0] req_operand_a;
  logic [4*N_REQ-1:0] req_operand_b;
  logic [2*N_REQ-1:0] req_operation;
  logic [N_REQ-1:0]   rsp_valid;
  logic [N_REQ-1:0]   rsp_ready;
  logic [3:0]         rsp_result;
  logic [IDW-1:0]     grant_id;
  logic [7:0]         op_count;

  modport master (
    output req_valid, req_operand_a, req_operand_b, req_operation, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, grant_id, op_count
  );

  modport slave (
    input  req_valid, req_operand_a, req_operand_b, req_operation, rsp_ready,
    output req_ready, rsp_valid, rsp_result, grant_id, op_count
  );
endinterface

// File: rtl/alu_4bits_core.sv
// Combinational 4-bit ALU; results wrap mod 16, no carry out.
module alu_4bits_core
  import alu_4bits_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] op,
  output logic [3:0] y
);
  always_comb begin
    y = a + b;
    case (op)
      ALU_OP_ADD: y = a + b;
      ALU_OP_SUB: y = a - b;
      ALU_OP_AND: y = a & b;
      ALU_OP_OR:  y = a | b;
      default:    y = a + b;
    endcase
  end
endmodule

// File: rtl/alu_4bits_sched.sv
// Round-robin scheduler sharing one 4-bit ALU across N_REQ requesters.
// IDLE accepts one request, EXEC latches the ALU result, RESP holds it until taken.
module alu_4bits_sched
  import alu_4bits_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input logic           clk,
  input logic           rst_n,
  alu_4bits_sched_if.slave bus
);
  sched_state_t     state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [3:0]       a_q, a_d, b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [3:0]       res_q, res_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [IDW-1:0]   sel;
  logic [3:0]       alu_y;
  logic [N_REQ-1:0] req_ready, rsp_valid;

  // First valid index at or after ptr, wrapping N_REQ-1 -> 0.
  function automatic logic [IDW-1:0] rr_select(input logic [N_REQ-1:0] v,
                                               input logic [IDW-1:0]   ptr);
    logic [IDW-1:0] s, j;
    logic           found;
    s     = ptr;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      j = IDW'((int'(ptr) + k) % N_REQ);
      if (!found && v[j]) begin
        found = 1'b1;
        s     = j;
      end
    end
    return s;
  endfunction

  alu_4bits_core u_core (.a(a_q), .b(b_q), .op(op_q), .y(alu_y));

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    rsp_valid = '0;
    sel       = rr_select(bus.req_valid, rr_ptr_q);
    case (state_q)
      IDLE: begin
        // Ready is held off while reset is asserted so nothing looks accepted.
        if (rst_n && |bus.req_valid) begin
          req_ready[sel] = 1'b1;
          grant_d        = sel;
          for (int i = 0; i < N_REQ; i++) begin
            if (sel == IDW'(i)) begin
              a_d  = bus.req_operand_a[4*i +: 4];
              b_d  = bus.req_operand_b[4*i +: 4];
              op_d = bus.req_operation[2*i +: 2];
            end
          end
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_y;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid[grant_q] = 1'b1;
        if (bus.rsp_ready[grant_q]) begin
          rr_ptr_d = (grant_q == IDW'(N_REQ - 1)) ? '0 : grant_q + IDW'(1);
          cnt_d    = cnt_q + 8'd1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_result = res_q;
  assign bus.grant_id   = grant_q;
  assign bus.op_count   = cnt_q;
endmodule

// File: tb/tb_alu_4bits_sched.sv
// Directed bench for alu_4bits_sched: single op, all ops, backpressure, contention, reset, wrap.
module tb_alu_4bits_sched;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_4bits_sched_if #(.N_REQ(N)) bus ();

  alu_4bits_sched #(.N_REQ(N)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] op);
    bus.req_operand_a[4*idx +: 4] = a;
    bus.req_operand_b[4*idx +: 4] = b;
    bus.req_operation[2*idx +: 2] = op;
  endtask

  // Called at posedge+1 in IDLE; returns at posedge+1 after the response handshake.
  task automatic do_op(input string tag, input int idx, input logic [3:0] a,
                       input logic [3:0] b, input logic [1:0] op, input logic [3:0] exp);
    set_req(idx, a, b, op);
    bus.req_valid[idx] = 1'b1;
    @(negedge clk);
    chk({tag, ".rdy"}, 32'(bus.req_ready), 32'(1) << idx);
    @(posedge clk); #1;
    bus.req_valid[idx] = 1'b0;
    @(negedge clk);
    chk({tag, ".exec_rsp"}, 32'(bus.rsp_valid), 0);
    @(negedge clk);
    chk({tag, ".rsp"}, 32'(bus.rsp_valid), 32'(1) << idx);
    chk({tag, ".res"}, 32'(bus.rsp_result), 32'(exp));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, cyc;
    bus.req_valid     = '0;
    bus.req_operand_a = '0;
    bus.req_operand_b = '0;
    bus.req_operation = '0;
    bus.rsp_ready     = '1;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.rdy", 32'(bus.req_ready), 0);
    chk("rst.rsp", 32'(bus.rsp_valid), 0);
    chk("rst.res", 32'(bus.rsp_result), 0);
    chk("rst.gid", 32'(bus.grant_id), 0);
    chk("rst.cnt", 32'(bus.op_count), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single request from requester 2: 9+8 = 17 -> 1
    do_op("single", 2, 4'd9, 4'd8, 2'b00, 4'd1);
    @(negedge clk);
    chk("single.cnt", 32'(bus.op_count), 1);
    chk("single.gid", 32'(bus.grant_id), 2);
    chk("single.rsp_off", 32'(bus.rsp_valid), 0);
    @(posedge clk); #1;

    // All ops on requester 0
    do_op("sub", 0, 4'd3, 4'd5, 2'b01, 4'd14);
    do_op("and", 0, 4'd3, 4'd5, 2'b10, 4'd1);
    do_op("or",  0, 4'd3, 4'd5, 2'b11, 4'd7);
    do_op("add_wrap", 0, 4'd15, 4'd15, 2'b00, 4'd14);
    @(negedge clk);
    chk("ops.cnt", 32'(bus.op_count), 5);
    @(posedge clk); #1;

    // Backpressure on requester 1 while requester 2 also waits
    set_req(1, 4'd6, 4'd3, 2'b01);
    set_req(2, 4'd12, 4'd10, 2'b10);
    bus.rsp_ready = 4'b1101;
    bus.req_valid = 4'b0110;
    @(negedge clk);
    chk("bp.rdy", 32'(bus.req_ready), 32'b0010);
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    @(negedge clk);
    chk("bp.exec_rdy", 32'(bus.req_ready), 0);
    @(negedge clk);
    chk("bp.rsp", 32'(bus.rsp_valid), 32'b0010);
    chk("bp.res", 32'(bus.rsp_result), 3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp.hold_rsp", 32'(bus.rsp_valid), 32'b0010);
      chk("bp.hold_res", 32'(bus.rsp_result), 3);
      chk("bp.hold_rdy", 32'(bus.req_ready), 0);
    end
    chk("bp.hold_cnt", 32'(bus.op_count), 5);
    @(posedge clk); #1;
    bus.rsp_ready[1] = 1'b1;
    @(negedge clk);
    chk("bp.hs_rsp", 32'(bus.rsp_valid), 32'b0010);
    @(negedge clk);
    chk("bp.done_rsp", 32'(bus.rsp_valid), 0);
    chk("bp.done_cnt", 32'(bus.op_count), 6);
    chk("bp.next_rdy", 32'(bus.req_ready), 32'b0100);
    @(posedge clk); #1;
    bus.req_valid[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bp2.rsp", 32'(bus.rsp_valid), 32'b0100);
    chk("bp2.res", 32'(bus.rsp_result), 8);
    @(negedge clk);
    chk("bp2.cnt", 32'(bus.op_count), 7);
    @(posedge clk); #1;

    // Contention from reset: requester i computes (i+1)+1
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 4'(i + 1), 4'd1, 2'b00);
    bus.req_valid = '1;
    bus.rsp_ready = '1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("cont.rdy", 32'(bus.req_ready), 32'(1) << (k % N));
      @(negedge clk);
      chk("cont.gid", 32'(bus.grant_id), 32'(k % N));
      chk("cont.exec_rdy", 32'(bus.req_ready), 0);
      @(negedge clk);
      chk("cont.rsp", 32'(bus.rsp_valid), 32'(1) << (k % N));
      chk("cont.res", 32'(bus.rsp_result), 32'((k % N) + 2));
    end
    @(negedge clk);
    chk("cont.cnt", 32'(bus.op_count), 5);
    chk("cont.next_rdy", 32'(bus.req_ready), 32'b0010);

    // Reset during EXEC of requester 1
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rmid.exec_rsp", 32'(bus.rsp_valid), 0);
    chk("rmid.exec_gid", 32'(bus.grant_id), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rmid.rsp", 32'(bus.rsp_valid), 0);
    chk("rmid.rdy", 32'(bus.req_ready), 0);
    chk("rmid.gid", 32'(bus.grant_id), 0);
    chk("rmid.res", 32'(bus.rsp_result), 0);
    chk("rmid.cnt", 32'(bus.op_count), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rmid.rr0", 32'(bus.req_ready), 32'b0001);

    // 256 back-to-back operations wrap op_count to 0
    hs  = 0;
    cyc = 1;
    while (hs < 256 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (|(bus.rsp_valid & bus.rsp_ready)) begin
        hs++;
        if (hs == 255) begin
          @(negedge clk);
          cyc++;
          chk("wrap.255", 32'(bus.op_count), 255);
        end
      end
    end
    chk("wrap.hs", 32'(hs), 256);
    chk("wrap.cycles", 32'(cyc), 768);
    @(negedge clk);
    chk("wrap.0", 32'(bus.op_count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
